// File: rtl/fp16_mul_arbiter.sv
// fp16_mul_arbiter: shares one fixed-latency FP16 multiplier among NUM_REQ requesters,
// tags in-flight ops and returns ID-tagged results. Macro FP16_MUL_ARB_FIXED_PRIO_EN selects fixed priority.
module fp16_mul_arbiter #(
    parameter int  NUM_REQ     = 4,
    parameter int  MUL_LATENCY = 3,
    parameter int  RESP_DEPTH  = 4,
    localparam int ID_W        = $clog2(NUM_REQ)
) (
    input  logic                    CLK,
    input  logic                    nRST,
    input  logic [NUM_REQ-1:0]      req_valid,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic [NUM_REQ*16-1:0]   req_a,
    input  logic [NUM_REQ*16-1:0]   req_b,
    output logic                    mul_in_valid,
    output logic [15:0]             mul_fp1,
    output logic [15:0]             mul_fp2,
    input  logic                    mul_out_valid,
    input  logic [15:0]             mul_out,
    output logic                    resp_valid,
    input  logic                    resp_ready,
    output logic [ID_W-1:0]         resp_id,
    output logic [15:0]             resp_data,
    output logic                    err_sticky
);

    localparam int PTR_W = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
    localparam int CNT_W = $clog2(RESP_DEPTH + 1);
    localparam int SUM_W = $clog2(RESP_DEPTH + MUL_LATENCY + 1);

    logic [MUL_LATENCY-1:0] tag_vld_q, tag_vld_d;
    logic [ID_W-1:0]        tag_id_q [MUL_LATENCY];
    logic [ID_W-1:0]        tag_id_d [MUL_LATENCY];
    logic [ID_W-1:0]        fifo_id_q [RESP_DEPTH];
    logic [ID_W-1:0]        fifo_id_d [RESP_DEPTH];
    logic [15:0]            fifo_data_q [RESP_DEPTH];
    logic [15:0]            fifo_data_d [RESP_DEPTH];
    logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic                   err_q, err_d;
`ifndef FP16_MUL_ARB_FIXED_PRIO_EN
    logic [ID_W-1:0]        ptr_q, ptr_d;
`endif

    logic [SUM_W-1:0]       inflight_s;
    logic                   can_issue_s, found_s, issue_s;
    logic                   push_s, push_ok_s, pop_s, full_s;
    logic [ID_W-1:0]        win_s;
    int                     idx_s;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(RESP_DEPTH - 1)) begin
            return '0;
        end else begin
            return p + PTR_W'(1);
        end
    endfunction

    // Credit check: results in flight plus queued may never exceed the FIFO.
    always_comb begin
        inflight_s = '0;
        for (int i = 0; i < MUL_LATENCY; i++) begin
            inflight_s = inflight_s + SUM_W'(tag_vld_q[i]);
        end
        can_issue_s = ((SUM_W'(count_q) + inflight_s) < SUM_W'(RESP_DEPTH)) && nRST;
    end

    // Winner search: first valid requester starting at the priority origin.
    always_comb begin
        found_s = 1'b0;
        win_s   = '0;
        idx_s   = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
`ifdef FP16_MUL_ARB_FIXED_PRIO_EN
            idx_s = k;
`else
            idx_s = (int'(ptr_q) + k) % NUM_REQ;
`endif
            if (!found_s && req_valid[idx_s]) begin
                found_s = 1'b1;
                win_s   = ID_W'(idx_s);
            end else begin
                found_s = found_s;
            end
        end
    end

    // Grant and operand steering toward the multiplier.
    always_comb begin
        issue_s   = found_s && can_issue_s;
        req_ready = '0;
        mul_fp1   = 16'h0000;
        mul_fp2   = 16'h0000;
        if (issue_s) begin
            req_ready[win_s] = 1'b1;
            mul_fp1          = req_a[int'(win_s)*16 +: 16];
            mul_fp2          = req_b[int'(win_s)*16 +: 16];
        end else begin
            req_ready = '0;
        end
        mul_in_valid = |(req_valid & req_ready);
    end

    // Next state: tag pipe shift, FIFO push/pop, error flag and RR pointer.
    always_comb begin
        pop_s     = (count_q != '0) && resp_ready;
        push_s    = tag_vld_q[MUL_LATENCY-1] && mul_out_valid;
        full_s    = (count_q == CNT_W'(RESP_DEPTH));
        push_ok_s = push_s && (!full_s || pop_s);

        tag_vld_d    = '0;
        tag_id_d     = tag_id_q;
        tag_vld_d[0] = mul_in_valid;
        tag_id_d[0]  = win_s;
        for (int i = 1; i < MUL_LATENCY; i++) begin
            tag_vld_d[i] = tag_vld_q[i-1];
            tag_id_d[i]  = tag_id_q[i-1];
        end

        // A strobe without a matching tag (or the reverse) means the pipe lost sync.
        err_d = err_q || (mul_out_valid != tag_vld_q[MUL_LATENCY-1]) || (push_s && !push_ok_s);

        fifo_id_d   = fifo_id_q;
        fifo_data_d = fifo_data_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        if (push_ok_s) begin
            fifo_id_d[wr_ptr_q]   = tag_id_q[MUL_LATENCY-1];
            fifo_data_d[wr_ptr_q] = mul_out;
            wr_ptr_d              = ptr_inc(wr_ptr_q);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        case ({push_ok_s, pop_s})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

`ifndef FP16_MUL_ARB_FIXED_PRIO_EN
        if (issue_s) begin
            ptr_d = (win_s == ID_W'(NUM_REQ - 1)) ? '0 : win_s + ID_W'(1);
        end else begin
            ptr_d = ptr_q;
        end
`endif
    end

    // State registers with asynchronous clear of all in-flight and queued work.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            tag_vld_q   <= '0;
            tag_id_q    <= '{default: '0};
            fifo_id_q   <= '{default: '0};
            fifo_data_q <= '{default: 16'h0000};
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            err_q       <= 1'b0;
`ifndef FP16_MUL_ARB_FIXED_PRIO_EN
            ptr_q       <= '0;
`endif
        end else begin
            tag_vld_q   <= tag_vld_d;
            tag_id_q    <= tag_id_d;
            fifo_id_q   <= fifo_id_d;
            fifo_data_q <= fifo_data_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            err_q       <= err_d;
`ifndef FP16_MUL_ARB_FIXED_PRIO_EN
            ptr_q       <= ptr_d;
`endif
        end
    end

    assign resp_valid = (count_q != '0);
    assign resp_id    = fifo_id_q[rd_ptr_q];
    assign resp_data  = fifo_data_q[rd_ptr_q];
    assign err_sticky = err_q;

endmodule

// File: tb/tb_fp16_mul_arbiter.sv
// Directed bench for fp16_mul_arbiter with a 3-stage multiplier stand-in and a response log.
module tb_fp16_mul_arbiter;

`ifdef FP16_MUL_ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic        CLK = 1'b0;
    logic        nRST = 1'b0;
    logic [3:0]  req_valid, req_ready;
    logic [63:0] req_a, req_b;
    logic        mul_in_valid, mul_out_valid, resp_valid, resp_ready, err_sticky;
    logic [15:0] mul_fp1, mul_fp2, mul_out, resp_data;
    logic [1:0]  resp_id;
    logic        inject = 1'b0;
    logic [2:0]  pv;
    logic [15:0] pd0, pd1, pd2;
    logic [17:0] rq[$];
    int          n_vec = 0;
    int          n_err = 0;
    int          g, c, issues;
    logic [3:0]  eg;

    fp16_mul_arbiter dut (
        .CLK(CLK), .nRST(nRST), .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .mul_in_valid(mul_in_valid),
        .mul_fp1(mul_fp1), .mul_fp2(mul_fp2), .mul_out_valid(mul_out_valid),
        .mul_out(mul_out), .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_id(resp_id), .resp_data(resp_data), .err_sticky(err_sticky)
    );

    always #5 CLK = ~CLK;

    function automatic logic [15:0] fp_model(input logic [15:0] a, input logic [15:0] b);
        case ({a, b})
            32'h3C003C00: return 16'h3C00;
            32'h3C004000: return 16'h4000;
            32'h40004000: return 16'h4400;
            32'h40004200: return 16'h4600;
            default:      return 16'h7E00;
        endcase
    endfunction

    function automatic logic [15:0] lane_prod(input int id);
        case (id)
            0:       return 16'h3C00;
            1:       return 16'h4000;
            2:       return 16'h4400;
            default: return 16'h4600;
        endcase
    endfunction

    // Multiplier stand-in: fixed 3-cycle latency, flushed by reset.
    always @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            pv  <= 3'b000;
            pd0 <= 16'h0000;
            pd1 <= 16'h0000;
            pd2 <= 16'h0000;
        end else begin
            pv  <= {pv[1:0], mul_in_valid};
            pd0 <= fp_model(mul_fp1, mul_fp2);
            pd1 <= pd0;
            pd2 <= pd1;
        end
    end
    assign mul_out_valid = pv[2] | inject;
    assign mul_out       = inject ? 16'h1234 : pd2;

    // Log of every accepted response.
    always @(posedge CLK) begin
        if (nRST && resp_valid && resp_ready) rq.push_back({resp_id, resp_data});
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wait_resp(input int n);
        int k = 0;
        while (rq.size() < n && k < 100) begin
            @(negedge CLK);
            k++;
        end
        chk("resp_count", rq.size(), n);
    endtask

    task automatic chk_resp(input string tag, input int i, input logic [1:0] id, input logic [15:0] d);
        logic [17:0] got;
        got = (i < rq.size()) ? rq[i] : 18'h3FFFF;
        chk($sformatf("%s%0d", tag, i), {14'b0, got}, {14'b0, id, d});
    endtask

    initial begin
        req_valid  = 4'b1111;
        resp_ready = 1'b0;
        req_a      = {16'h4000, 16'h4000, 16'h3C00, 16'h3C00};
        req_b      = {16'h4200, 16'h4000, 16'h4000, 16'h3C00};
        repeat (2) @(negedge CLK);
        #1;
        chk("rst_ready", {28'b0, req_ready}, 32'h0);
        chk("rst_mul_in_valid", {31'b0, mul_in_valid}, 32'h0);
        chk("rst_resp_valid", {31'b0, resp_valid}, 32'h0);
        chk("rst_err", {31'b0, err_sticky}, 32'h0);
        chk("rst_fp1", {16'b0, mul_fp1}, 32'h0);
        @(negedge CLK);
        nRST = 1'b1;
        req_valid = 4'b0000;
        resp_ready = 1'b1;
        @(negedge CLK);

        // Fairness: all lanes request until eight grants.
        rq.delete();
        req_valid = 4'b1111;
        g = 0;
        c = 0;
        while (g < 8 && c < 60) begin
            #1;
            if (mul_in_valid) begin
                eg = FIXED ? 4'b0001 : (4'b0001 << (g % 4));
                chk($sformatf("rr_grant%0d", g), {28'b0, req_ready}, {28'b0, eg});
                g++;
            end
            c++;
            @(negedge CLK);
        end
        req_valid = 4'b0000;
        chk("rr_grants", g, 8);
        wait_resp(8);
        for (int i = 0; i < 8; i++) begin
            chk_resp("rr_resp", i, FIXED ? 2'd0 : 2'(i % 4), FIXED ? 16'h3C00 : lane_prod(i % 4));
        end

        // Single op and its latency.
        @(negedge CLK);
        rq.delete();
        req_valid = 4'b0010;
        #1;
        chk("single_ready", {28'b0, req_ready}, 32'h2);
        chk("single_issue", {31'b0, mul_in_valid}, 32'h1);
        chk("single_fp1", {16'b0, mul_fp1}, 32'h3C00);
        chk("single_fp2", {16'b0, mul_fp2}, 32'h4000);
        @(negedge CLK);
        req_valid = 4'b0000;
        #1;
        chk("single_lat1", {31'b0, resp_valid}, 32'h0);
        repeat (2) @(negedge CLK);
        #1;
        chk("single_lat3", {31'b0, resp_valid}, 32'h0);
        @(negedge CLK);
        #1;
        chk("single_lat4", {31'b0, resp_valid}, 32'h1);
        chk("single_id", {30'b0, resp_id}, 32'h1);
        chk("single_data", {16'b0, resp_data}, 32'h4000);
        @(negedge CLK);
        #1;
        chk("single_popped", {31'b0, resp_valid}, 32'h0);

        // Backpressure: credit limits issues to FIFO depth.
        @(negedge CLK);
        rq.delete();
        resp_ready = 1'b0;
        req_valid = 4'b0101;
        issues = 0;
        for (int k = 0; k < 12; k++) begin
            #1;
            if (mul_in_valid) begin
                eg = FIXED ? 4'b0001 : ((issues % 2 == 0) ? 4'b0100 : 4'b0001);
                chk($sformatf("bp_grant%0d", issues), {28'b0, req_ready}, {28'b0, eg});
                issues++;
            end
            @(negedge CLK);
        end
        #1;
        chk("bp_issues", issues, 4);
        chk("bp_blocked", {28'b0, req_ready}, 32'h0);
        chk("bp_head_valid", {31'b0, resp_valid}, 32'h1);
        chk("bp_head_id", {30'b0, resp_id}, FIXED ? 32'h0 : 32'h2);
        @(negedge CLK);
        #1;
        chk("bp_stable_id", {30'b0, resp_id}, FIXED ? 32'h0 : 32'h2);
        chk("bp_stable_data", {16'b0, resp_data}, FIXED ? 32'h3C00 : 32'h4400);
        resp_ready = 1'b1;
        @(negedge CLK);
        resp_ready = 1'b0;
        #1;
        chk("bp_regrant", {28'b0, req_ready}, FIXED ? 32'h1 : 32'h4);
        @(negedge CLK);
        #1;
        chk("bp_reblock", {28'b0, req_ready}, 32'h0);
        req_valid = 4'b0000;
        resp_ready = 1'b1;
        wait_resp(5);
        for (int i = 0; i < 5; i++) begin
            chk_resp("bp_resp", i, (FIXED || (i % 2 == 1)) ? 2'd0 : 2'd2,
                     (FIXED || (i % 2 == 1)) ? 16'h3C00 : 16'h4400);
        end

        // Twenty back-to-back ops with a filled FIFO draining underneath.
        @(negedge CLK);
        rq.delete();
        req_a[31:16] = 16'h4000;
        req_b[31:16] = 16'h4200;
        resp_ready = 1'b0;
        req_valid = 4'b0010;
        g = 0;
        c = 0;
        while (g < 20 && c < 300) begin
            #1;
            if (mul_in_valid) g++;
            if (c == 6) resp_ready = 1'b1;
            c++;
            @(negedge CLK);
        end
        req_valid = 4'b0000;
        resp_ready = 1'b1;
        chk("wrap_issues", g, 20);
        wait_resp(20);
        for (int i = 0; i < 20; i++) chk_resp("wrap_resp", i, 2'd1, 16'h4600);

        // Result strobe with nothing in flight.
        @(negedge CLK);
        rq.delete();
        #1;
        chk("err_pre", {31'b0, err_sticky}, 32'h0);
        inject = 1'b1;
        @(negedge CLK);
        inject = 1'b0;
        #1;
        chk("err_set", {31'b0, err_sticky}, 32'h1);
        chk("err_no_push", {31'b0, resp_valid}, 32'h0);
        repeat (3) @(negedge CLK);
        #1;
        chk("err_hold", {31'b0, err_sticky}, 32'h1);
        chk("err_log_empty", rq.size(), 0);

        // Reset with results queued and ops in flight.
        @(negedge CLK);
        rq.delete();
        resp_ready = 1'b0;
        req_valid = 4'b0001;
        repeat (2) @(negedge CLK);
        req_valid = 4'b0000;
        repeat (3) @(negedge CLK);
        req_valid = 4'b0110;
        repeat (2) @(negedge CLK);
        #1;
        chk("pre_rst_valid", {31'b0, resp_valid}, 32'h1);
        req_valid = 4'b1111;
        nRST = 1'b0;
        #1;
        chk("mid_rst_ready", {28'b0, req_ready}, 32'h0);
        chk("mid_rst_issue", {31'b0, mul_in_valid}, 32'h0);
        chk("mid_rst_resp", {31'b0, resp_valid}, 32'h0);
        chk("mid_rst_err", {31'b0, err_sticky}, 32'h0);
        chk("mid_rst_fp2", {16'b0, mul_fp2}, 32'h0);
        chk("mid_rst_data", {16'b0, resp_data}, 32'h0);
        @(negedge CLK);
        nRST = 1'b1;
        req_valid = 4'b1000;
        #1;
        chk("post_rst_grant", {28'b0, req_ready}, 32'h8);
        chk("post_rst_fp1", {16'b0, mul_fp1}, 32'h4000);
        resp_ready = 1'b1;
        @(negedge CLK);
        req_valid = 4'b0000;
        wait_resp(1);
        chk_resp("post_rst_resp", 0, 2'd3, 16'h4600);
        chk("post_rst_err", {31'b0, err_sticky}, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: run did not complete, vectors=%0d miscompares=%0d", n_vec, n_err);
        $fatal(1, "watchdog expired");
    end

endmodule
